// File: rtl/stream_xfer_ctrl_if.sv
// Single-word memory port shared by the LD and ST channels.
//   req  : beat request (master -> slave)
//   we   : 1 = store beat, 0 = load beat (master -> slave)
//   addr : beat address, stable while req is high and ack is low (master -> slave)
//   ack  : beat accepted this cycle when req is high (slave -> master)
interface stream_xfer_ctrl_if #(
    parameter int unsigned CPU_W = 16
) ();
    logic             req;
    logic             we;
    logic [CPU_W-1:0] addr;
    logic             ack;

    modport master (
        output req,
        output we,
        output addr,
        input  ack
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        output ack
    );
endinterface

// File: rtl/stream_xfer_ctrl.sv
// Streamed load/store transfer sequencer.
// Two channels (LD, ST) each walk an address range of dnum words starting at sa,
// sharing one single-word memory port through a round-robin arbiter. When a
// channel finishes it writes its final address and a zero count back to the
// register file and pulses its done flag.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   i_ld_start / i_st_start   start pulses, ignored while the channel is busy
//   i_sa_* / i_dnum_*         start address / word count, sampled on accepted start
//   o_ld_busy / o_st_busy     channel not idle
//   mem                       memory port (req/we/addr out, ack in)
//   o_ld_valid / o_st_pop     beat accepted for LD / ST this cycle
//   o_we_* / o_*_wb           register-file write-back strobes and values
//   o_ld_done / o_st_done     one-cycle completion pulses
module stream_xfer_ctrl #(
    parameter int unsigned CPU_W  = 16,
    parameter int unsigned STRIDE = 1
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                i_ld_start,
    input  logic                i_st_start,
    input  logic [CPU_W-1:0]    i_sa_ld,
    input  logic [CPU_W-1:0]    i_dnum_ld,
    input  logic [CPU_W-1:0]    i_sa_st,
    input  logic [CPU_W-1:0]    i_dnum_st,

    output logic                o_ld_busy,
    output logic                o_st_busy,

    stream_xfer_ctrl_if.master  mem,

    output logic                o_ld_valid,
    output logic                o_st_pop,

    output logic                o_we_sa_ld,
    output logic [CPU_W-1:0]    o_sa_ld_wb,
    output logic                o_we_dnum_ld,
    output logic [CPU_W-1:0]    o_dnum_ld_wb,
    output logic                o_we_sa_st,
    output logic [CPU_W-1:0]    o_sa_st_wb,
    output logic                o_we_dnum_st,
    output logic [CPU_W-1:0]    o_dnum_st_wb,

    output logic                o_ld_done,
    output logic                o_st_done
);

    localparam int unsigned N_CH  = 2;
    localparam logic        CH_LD = 1'b0;
    localparam logic        CH_ST = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WB   = 2'd2
    } state_e;

    // Per-channel state, indexed by CH_LD / CH_ST
    state_e             state_q [N_CH];
    state_e             state_d [N_CH];
    logic [CPU_W-1:0]   addr_q  [N_CH];
    logic [CPU_W-1:0]   addr_d  [N_CH];
    logic [CPU_W-1:0]   cnt_q   [N_CH];
    logic [CPU_W-1:0]   cnt_d   [N_CH];

    logic [CPU_W-1:0]   sa_c    [N_CH];
    logic [CPU_W-1:0]   dnum_c  [N_CH];
    logic [N_CH-1:0]    start_c;
    logic [N_CH-1:0]    req_c;
    logic [N_CH-1:0]    beat_c;
    logic [N_CH-1:0]    wb_c;

    // Arbiter state: held owner, and the channel served last
    logic               own_vld_q;
    logic               own_q;
    logic               last_q;
    logic               sel_c;
    logic               mem_req_c;
    logic               accept_c;

    // Map the per-channel inputs onto channel-indexed vectors
    assign start_c        = {i_st_start, i_ld_start};
    assign sa_c[CH_LD]    = i_sa_ld;
    assign sa_c[CH_ST]    = i_sa_st;
    assign dnum_c[CH_LD]  = i_dnum_ld;
    assign dnum_c[CH_ST]  = i_dnum_st;

    // A channel requests while running with beats left
    always_comb begin
        req_c = '0;
        wb_c  = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            req_c[i] = (state_q[i] == ST_RUN) && (cnt_q[i] != '0);
            wb_c[i]  = (state_q[i] == ST_WB);
        end
    end

    // Owner select: a held owner wins; otherwise alternate on contention
    always_comb begin
        sel_c = own_q;
        if (!own_vld_q) begin
            if (&req_c) begin
                sel_c = ~last_q;
            end else begin
                sel_c = req_c[CH_ST];
            end
        end
        mem_req_c      = req_c[sel_c];
        accept_c       = mem_req_c & mem.ack;
        beat_c         = '0;
        beat_c[sel_c]  = accept_c;
    end

    // Arbiter registers: hold the owner across stalls, release after a beat
    always_ff @(posedge clk) begin
        if (rst) begin
            own_vld_q <= 1'b0;
            own_q     <= CH_LD;
            last_q    <= CH_ST;
        end else if (accept_c) begin
            own_vld_q <= 1'b0;
            last_q    <= sel_c;
        end else if (mem_req_c) begin
            own_vld_q <= 1'b1;
            own_q     <= sel_c;
        end
    end

    // Channel next-state: IDLE -> RUN -> WB -> IDLE
    always_comb begin
        for (int unsigned i = 0; i < N_CH; i++) begin
            state_d[i] = state_q[i];
            addr_d[i]  = addr_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                ST_IDLE: begin
                    if (start_c[i]) begin
                        state_d[i] = ST_RUN;
                        addr_d[i]  = sa_c[i];
                        cnt_d[i]   = dnum_c[i];
                    end
                end
                ST_RUN: begin
                    if (cnt_q[i] == '0) begin
                        state_d[i] = ST_WB;
                    end else if (beat_c[i]) begin
                        addr_d[i] = addr_q[i] + CPU_W'(STRIDE);
                        cnt_d[i]  = cnt_q[i] - CPU_W'(1);
                        // Last beat goes straight to write-back
                        if (cnt_q[i] == CPU_W'(1)) begin
                            state_d[i] = ST_WB;
                        end
                    end
                end
                ST_WB: begin
                    state_d[i] = ST_IDLE;
                end
                default: begin
                    state_d[i] = ST_IDLE;
                end
            endcase
        end
    end

    // Channel state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                state_q[i] <= ST_IDLE;
                addr_q[i]  <= '0;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                state_q[i] <= state_d[i];
                addr_q[i]  <= addr_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Memory port: address and direction are zero whenever no beat is requested
    assign mem.req  = mem_req_c;
    assign mem.we   = mem_req_c & sel_c;
    assign mem.addr = mem_req_c ? addr_q[sel_c] : '0;

    assign o_ld_valid = beat_c[CH_LD];
    assign o_st_pop   = beat_c[CH_ST];

    assign o_ld_busy  = (state_q[CH_LD] != ST_IDLE);
    assign o_st_busy  = (state_q[CH_ST] != ST_IDLE);

    // Write-back: final address and a zero count during the single WB cycle
    assign o_we_sa_ld   = wb_c[CH_LD];
    assign o_sa_ld_wb   = wb_c[CH_LD] ? addr_q[CH_LD] : '0;
    assign o_we_dnum_ld = wb_c[CH_LD];
    assign o_dnum_ld_wb = '0;
    assign o_ld_done    = wb_c[CH_LD];

    assign o_we_sa_st   = wb_c[CH_ST];
    assign o_sa_st_wb   = wb_c[CH_ST] ? addr_q[CH_ST] : '0;
    assign o_we_dnum_st = wb_c[CH_ST];
    assign o_dnum_st_wb = '0;
    assign o_st_done    = wb_c[CH_ST];

endmodule

// File: tb/tb_stream_xfer_ctrl.sv
// Testbench for stream_xfer_ctrl: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level reference model.
module tb_stream_xfer_ctrl;

    localparam int unsigned CPU_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             i_ld_start, i_st_start;
    logic [CPU_W-1:0] i_sa_ld, i_dnum_ld, i_sa_st, i_dnum_st;
    logic             o_ld_busy, o_st_busy, o_ld_valid, o_st_pop;
    logic             o_we_sa_ld, o_we_dnum_ld, o_we_sa_st, o_we_dnum_st;
    logic [CPU_W-1:0] o_sa_ld_wb, o_dnum_ld_wb, o_sa_st_wb, o_dnum_st_wb;
    logic             o_ld_done, o_st_done;

    stream_xfer_ctrl_if #(.CPU_W(CPU_W)) mem ();

    stream_xfer_ctrl #(.CPU_W(CPU_W), .STRIDE(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_ld_start   (i_ld_start),
        .i_st_start   (i_st_start),
        .i_sa_ld      (i_sa_ld),
        .i_dnum_ld    (i_dnum_ld),
        .i_sa_st      (i_sa_st),
        .i_dnum_st    (i_dnum_st),
        .o_ld_busy    (o_ld_busy),
        .o_st_busy    (o_st_busy),
        .mem          (mem),
        .o_ld_valid   (o_ld_valid),
        .o_st_pop     (o_st_pop),
        .o_we_sa_ld   (o_we_sa_ld),
        .o_sa_ld_wb   (o_sa_ld_wb),
        .o_we_dnum_ld (o_we_dnum_ld),
        .o_dnum_ld_wb (o_dnum_ld_wb),
        .o_we_sa_st   (o_we_sa_st),
        .o_sa_st_wb   (o_sa_st_wb),
        .o_we_dnum_st (o_we_dnum_st),
        .o_dnum_st_wb (o_dnum_st_wb),
        .o_ld_done    (o_ld_done),
        .o_st_done    (o_st_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference model: per channel, whether a transfer is open, beats still owed,
    // the next beat address, and whether this cycle is the write-back cycle.
    bit               m_busy [2];
    bit               m_wb   [2];
    int               m_left [2];
    logic [CPU_W-1:0] m_addr [2];
    bit               m_held, m_holder, m_last;

    // Observation log of accepted beats {we, addr} and completion events
    logic [16:0]      beat_log [$];
    int               cyc = 0;
    int               ld_done_n, st_done_n, ld_done_cyc;
    logic [CPU_W-1:0] ld_wb_last, st_wb_last;

    function automatic void model_reset();
        for (int c = 0; c < 2; c++) begin
            m_busy[c] = 1'b0;
            m_wb[c]   = 1'b0;
            m_left[c] = 0;
            m_addr[c] = '0;
        end
        m_held   = 1'b0;
        m_holder = 1'b0;
        m_last   = 1'b1;
    endfunction

    function automatic void clear_obs();
        beat_log.delete();
        ld_done_n = 0;
        st_done_n = 0;
        ld_done_cyc = -1;
        ld_wb_last = '0;
        st_wb_last = '0;
    endfunction

    // One clock cycle: drive, compare against the model, then advance the model
    task automatic step(input logic ls, input logic ss,
                        input logic [CPU_W-1:0] sl, input logic [CPU_W-1:0] dl,
                        input logic [CPU_W-1:0] s2, input logic [CPU_W-1:0] d2,
                        input logic ack, input logic r);
        bit want [2];
        bit own, exp_req, exp_acc, acc_c, st_in;
        @(negedge clk);
        i_ld_start = ls;  i_st_start = ss;
        i_sa_ld = sl;     i_dnum_ld = dl;
        i_sa_st = s2;     i_dnum_st = d2;
        mem.ack = ack;    rst = r;
        #1;
        for (int c = 0; c < 2; c++) want[c] = m_busy[c] && !m_wb[c] && (m_left[c] > 0);
        if (m_held)                own = m_holder;
        else if (want[0] && want[1]) own = !m_last;
        else                       own = want[1];
        exp_req = want[own];
        exp_acc = exp_req && ack;

        check("mem_port", {mem.req, mem.we, mem.addr},
              {exp_req, exp_req && own, (exp_req ? m_addr[own] : 16'h0)});
        check("beat", {o_ld_valid, o_st_pop}, {exp_acc && !own, exp_acc && own});
        check("busy", {o_ld_busy, o_st_busy}, {m_busy[0], m_busy[1]});
        check("wb_ld", {o_we_sa_ld, o_sa_ld_wb, o_we_dnum_ld, o_dnum_ld_wb, o_ld_done},
              {m_wb[0], (m_wb[0] ? m_addr[0] : 16'h0), m_wb[0], 16'h0, m_wb[0]});
        check("wb_st", {o_we_sa_st, o_sa_st_wb, o_we_dnum_st, o_dnum_st_wb, o_st_done},
              {m_wb[1], (m_wb[1] ? m_addr[1] : 16'h0), m_wb[1], 16'h0, m_wb[1]});

        if (mem.req && ack) beat_log.push_back({mem.we, mem.addr});
        if (o_ld_done) begin ld_done_n++; ld_wb_last = o_sa_ld_wb; ld_done_cyc = cyc; end
        if (o_st_done) begin st_done_n++; st_wb_last = o_sa_st_wb; end

        if (r) begin
            model_reset();
        end else begin
            for (int c = 0; c < 2; c++) begin
                acc_c = exp_acc && (int'(own) == c);
                st_in = (c == 0) ? ls : ss;
                if (m_wb[c]) begin
                    m_wb[c] = 1'b0;
                    m_busy[c] = 1'b0;
                end else if (m_busy[c]) begin
                    if (acc_c) begin
                        m_addr[c] = m_addr[c] + 16'd1;
                        m_left[c]--;
                        if (m_left[c] == 0) m_wb[c] = 1'b1;
                    end else if (m_left[c] == 0) begin
                        m_wb[c] = 1'b1;
                    end
                end else if (st_in) begin
                    m_busy[c] = 1'b1;
                    m_addr[c] = (c == 0) ? sl : s2;
                    m_left[c] = int'((c == 0) ? dl : d2);
                end
            end
            if (exp_acc) begin
                m_held = 1'b0;
                m_last = own;
            end else if (exp_req) begin
                m_held   = 1'b1;
                m_holder = own;
            end
        end
        cyc++;
    endtask

    task automatic idle(input logic ack, input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, '0, '0, '0, '0, ack, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b1);
        clear_obs();
    endtask

    task automatic check_log(input string tag, input logic [16:0] exp[$]);
        check({tag, "_len"}, 64'(beat_log.size()), 64'(exp.size()));
        for (int k = 0; k < exp.size(); k++) begin
            if (k < beat_log.size()) check(tag, 64'(beat_log[k]), 64'(exp[k]));
            else                     check(tag, 64'h1_ffff_ffff, 64'(exp[k]));
        end
    endtask

    initial begin
        rst = 1'b1;
        i_ld_start = 1'b0; i_st_start = 1'b0;
        i_sa_ld = '0; i_dnum_ld = '0; i_sa_st = '0; i_dnum_st = '0;
        mem.ack = 1'b0;
        repeat (2) @(posedge clk);
        model_reset();
        clear_obs();
        #1;
        check("reset_outs",
              {o_ld_busy, o_st_busy, mem.req, mem.we, mem.addr, o_ld_valid, o_st_pop,
               o_we_sa_ld, o_we_dnum_ld, o_we_sa_st, o_we_dnum_st, o_ld_done, o_st_done},
              '0);

        // 1. LD sa=0x0100 n=3, ack high
        step(1'b1, 1'b0, 16'h0100, 16'd3, '0, '0, 1'b1, 1'b0);
        idle(1'b1, 6);
        check_log("t1_beats", '{17'h00100, 17'h00101, 17'h00102});
        check("t1_done_n", 64'(ld_done_n), 64'd1);
        check("t1_sa_wb", 64'(ld_wb_last), 64'h0103);

        // 2. LD and ST start together, alternate starting with LD
        do_reset();
        step(1'b1, 1'b1, 16'h0010, 16'd2, 16'h0080, 16'd2, 1'b1, 1'b0);
        idle(1'b1, 7);
        check_log("t2_beats", '{17'h00010, 17'h10080, 17'h00011, 17'h10081});
        check("t2_done", 64'({ld_done_n, st_done_n}), 64'({32'd1, 32'd1}));

        // 3. ST n=2 with ack held low for three cycles
        do_reset();
        step(1'b0, 1'b1, '0, '0, 16'h0040, 16'd2, 1'b0, 1'b0);
        idle(1'b0, 3);
        idle(1'b1, 5);
        check_log("t3_beats", '{17'h10040, 17'h10041});
        check("t3_sa_wb", 64'(st_wb_last), 64'h0042);

        // 4. dnum=0: no beats, write-back two cycles after start
        do_reset();
        begin
            int s;
            s = cyc;
            step(1'b1, 1'b0, 16'h0055, 16'd0, '0, '0, 1'b1, 1'b0);
            idle(1'b1, 4);
            check("t4_latency", 64'(ld_done_cyc - s), 64'd2);
        end
        check_log("t4_beats", '{});
        check("t4_sa_wb", 64'(ld_wb_last), 64'h0055);

        // 5. address wrap
        do_reset();
        step(1'b1, 1'b0, 16'hFFFF, 16'd2, '0, '0, 1'b1, 1'b0);
        idle(1'b1, 5);
        check_log("t5_beats", '{17'h0FFFF, 17'h00000});
        check("t5_sa_wb", 64'(ld_wb_last), 64'h0001);

        // 6. start during busy is dropped; reset mid-run aborts with no write-back
        do_reset();
        step(1'b1, 1'b0, 16'h0300, 16'd5, '0, '0, 1'b0, 1'b0);
        idle(1'b0, 2);
        step(1'b1, 1'b0, 16'h03A0, 16'd1, '0, '0, 1'b1, 1'b0);
        idle(1'b1, 1);
        step(1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b1);
        idle(1'b1, 6);
        check_log("t6_beats", '{17'h00300, 17'h00301});
        check("t6_no_wb", 64'(ld_done_n), 64'd0);
        check("t6_idle", {o_ld_busy, mem.req}, 2'b00);
        clear_obs();
        step(1'b1, 1'b0, 16'h0200, 16'd1, '0, '0, 1'b1, 1'b0);
        idle(1'b1, 4);
        check_log("t6_restart", '{17'h00200});
        check("t6_sa_wb", 64'(ld_wb_last), 64'h0201);

        // Randomized traffic
        do_reset();
        for (int k = 0; k < 800; k++) begin
            step(1'($urandom % 6 == 0), 1'($urandom % 6 == 0),
                 16'($urandom), 16'($urandom_range(4, 0)),
                 16'($urandom), 16'($urandom_range(4, 0)),
                 1'($urandom % 4 != 0), 1'($urandom % 250 == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
